// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: single-port data memory owner; drains store buffer, serves loads (forward or read), starvation-bounded stores.
// Optional perf counters enabled by DMEM_PERF_CNT_EN.
module dmem_port_ctrl #(
    parameter int TAG_W      = 4,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_req,
    input  logic [9:0]       ld_addr,
    input  logic [TAG_W-1:0] ld_tag,
    output logic             ld_ready,
    input  logic             fwd_hit,
    input  logic [31:0]      fwd_data,
    input  logic             sb_valid,
    input  logic [9:0]       sb_addr,
    input  logic [31:0]      sb_data,
    output logic             sb_inc,
    output logic             mem_en,
    output logic             mem_we,
    output logic [9:0]       mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [15:0]      perf_ld_fwd,
    output logic [15:0]      perf_ld_mem,
    output logic [15:0]      perf_starve
`endif
);
    typedef enum logic [1:0] {IDLE, LD_CHK, LD_WAIT} state_e;
    state_e           state_q;
    logic [3:0]       starve_q, starve_d;
    logic [2:0]       lat_q;
    logic [9:0]       addr_q;
    logic [TAG_W-1:0] tag_q;
    logic             cdb_valid_q;
    logic [TAG_W-1:0] cdb_tag_q;
    logic [31:0]      cdb_data_q;
    logic             forced, ld_acc, st_issue, rd_issue;

    always_comb begin
        forced    = (state_q == IDLE) && (starve_q == 4'(STARVE_LIM));
        ld_ready  = (state_q == IDLE) && !forced;
        ld_acc    = ld_ready && ld_req;
        st_issue  = (state_q == IDLE) && sb_valid && !ld_acc;
        rd_issue  = (state_q == LD_CHK) && !fwd_hit;
        mem_en    = st_issue || rd_issue;
        mem_we    = st_issue;
        mem_addr  = rd_issue ? addr_q : sb_addr;
        mem_wdata = sb_data;
        sb_inc    = st_issue;
        starve_d  = (st_issue || !sb_valid) ? 4'd0 :
                    (starve_q == 4'(STARVE_LIM)) ? starve_q : starve_q + 4'd1;
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

    // lat_q hits 1 in the cycle mem_rdata is valid; capture there so cdb pulses as it reaches 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            lat_q       <= 3'd0;
            addr_q      <= 10'd0;
            tag_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= 32'd0;
        end else begin
            starve_q    <= starve_d;
            cdb_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (ld_acc) begin
                    addr_q  <= ld_addr;
                    tag_q   <= ld_tag;
                    state_q <= LD_CHK;
                end
                LD_CHK: begin
                    state_q <= fwd_hit ? IDLE : LD_WAIT;
                    lat_q   <= 3'(MEM_LAT);
                    if (fwd_hit) begin
                        cdb_valid_q <= 1'b1;
                        cdb_tag_q   <= tag_q;
                        cdb_data_q  <= fwd_data;
                    end
                end
                LD_WAIT: begin
                    lat_q <= lat_q - 3'd1;
                    if (lat_q == 3'd1) begin
                        cdb_valid_q <= 1'b1;
                        cdb_tag_q   <= tag_q;
                        cdb_data_q  <= mem_rdata;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [15:0] perf_ld_fwd_q, perf_ld_mem_q, perf_starve_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ld_fwd_q <= 16'd0;
            perf_ld_mem_q <= 16'd0;
            perf_starve_q <= 16'd0;
        end else begin
            perf_ld_fwd_q <= perf_ld_fwd_q + {15'd0, (state_q == LD_CHK) && fwd_hit && (perf_ld_fwd_q != 16'hFFFF)};
            perf_ld_mem_q <= perf_ld_mem_q + {15'd0, rd_issue && (perf_ld_mem_q != 16'hFFFF)};
            perf_starve_q <= perf_starve_q + {15'd0, forced && st_issue && (perf_starve_q != 16'hFFFF)};
        end
    end
    assign perf_ld_fwd = perf_ld_fwd_q;
    assign perf_ld_mem = perf_ld_mem_q;
    assign perf_starve = perf_starve_q;
`else
`endif
endmodule

// File: doc/dmem_port_ctrl.md
Name: dmem_port_ctrl

Overview:
- Sole owner of the single-port data memory, directly downstream of the store buffer.
- Drains committed stores from the buffer head (sb_valid/sb_addr/sb_data) and pulses sb_inc to retire each one.
- Executes loads: forwards from the store buffer on a hit, otherwise reads memory, and broadcasts results on the CDB with the load's tag.
- Arbitrates load vs store access to memory with bounded store starvation.

Parameters:
- TAG_W, 4: width of the load ROB/RS tag.
- MEM_LAT, 1: cycles from a mem_en read cycle to mem_rdata valid; legal range 1..7.
- STARVE_LIM, 8: consecutive blocked cycles with sb_valid=1 before the pending store forces priority; legal range 1..15.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- ld_req  in  1  load request; accepted when ld_req & ld_ready.
- ld_addr  in  10  load word address; also drives the store buffer lookup address.
- ld_tag  in  TAG_W  tag of the load.
- ld_ready  out  1  block can accept a load this cycle.
- fwd_hit  in  1  store buffer forward hit; valid the cycle after acceptance.
- fwd_data  in  32  forwarded data; same timing as fwd_hit.
- sb_valid  in  1  a committed store is at the store buffer head.
- sb_addr  in  10  head store address.
- sb_data  in  32  head store data.
- sb_inc  out  1  one-cycle pulse that retires the head store.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable; qualified by mem_en.
- mem_addr  out  10  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- cdb_valid  out  1  load result valid; registered, one-cycle pulse.
- cdb_tag  out  TAG_W  result tag.
- cdb_data  out  32  result data.

Behaviour:
- Reset: state=IDLE, starve_cnt=0, lat_cnt=0. cdb_valid=0, cdb_tag=0, cdb_data=0, sb_inc=0, mem_en=0, mem_we=0. Asserting rst mid-load abandons the load with no CDB pulse.
- FSM states: IDLE, LD_CHK, LD_WAIT.
- IDLE, starve_cnt < STARVE_LIM:
  - ld_ready=1.
  - If ld_req: latch ld_addr/ld_tag, go to LD_CHK.
  - Else if sb_valid: issue the store this cycle (mem_en=1, mem_we=1, mem_addr=sb_addr, mem_wdata=sb_data, sb_inc=1); remain IDLE. Back-to-back stores are allowed, one per cycle.
- IDLE, starve_cnt == STARVE_LIM:
  - ld_ready=0.
  - Issue the store as above; starve_cnt clears.
- starve_cnt:
  - Increments each cycle sb_valid=1 and no store issues; saturates at STARVE_LIM.
  - Clears on every store issue and whenever sb_valid=0.
- LD_CHK (ld_ready=0):
  - fwd_hit=1: next cycle cdb_valid=1, cdb_data=fwd_data, cdb_tag=latched tag; no memory access; go to IDLE.
  - fwd_hit=0: mem_en=1, mem_we=0, mem_addr=latched addr; lat_cnt<=MEM_LAT; go to LD_WAIT.
- LD_WAIT (ld_ready=0):
  - lat_cnt decrements each cycle.
  - When it reaches 0, capture mem_rdata; cdb_valid pulses the next cycle; return to IDLE.
- Miss latency: accept at T, mem_en at T+1, cdb_valid at T+2+MEM_LAT. Hit latency: cdb_valid at T+2.
- Stores never issue outside IDLE; only one outstanding load.
- mem_en never asserts in two roles in one cycle. mem_we=0 whenever mem_en=0.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined: adds outputs perf_ld_fwd[15:0], perf_ld_mem[15:0], perf_starve[15:0].
  - perf_ld_fwd: forwarded loads.
  - perf_ld_mem: memory-read loads.
  - perf_starve: forced-store events.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with sb_valid=0, ld_req=0 -> all outputs 0, ld_ready=1; rst pulsed mid-LD_WAIT -> no cdb_valid, state IDLE.
- Three stores at head (addr 5,6,7; data 0xA,0xB,0xC), no loads -> mem_we pulses on 3 consecutive cycles with matching addr/data, sb_inc pulses on the same cycles.
- Load addr 0x10, tag 3, fwd_hit=1, fwd_data=0xDEADBEEF at T+1 -> cdb_valid at T+2, tag 3, data 0xDEADBEEF, mem_en never asserted.
- Load addr 0x20, tag 5, fwd_hit=0, MEM_LAT=2, memory holds 0x12345678 -> mem_en/read at T+1, cdb_valid at T+4 with 0x12345678, tag 5.
- sb_valid=1 held, ld_req asserted whenever ld_ready, STARVE_LIM=8 -> after 8 blocked cycles ld_ready=0 for one IDLE cycle, store issues, sb_inc=1, starve_cnt back to 0.
- Store pending and ld_req asserted in the same IDLE cycle (starve_cnt=0) -> load accepted, no write that cycle, store issues on the first IDLE cycle after the load completes.
